mips_bus_arbiter: RTL
=====================

// Module: mips_bus_arbiter
// PURPOSE
//  Two-master, one-slave arbiter for the CPU memory bus (address/read/write/byteenable/writedata/readdata/waitrequest).
//  Shares one memory port between M0 (instruction fetch) and M1 (load/store).
//  Registered grant FSM holds ownership until the slave completes the transfer (waitrequest low).
//  Sticky timeout flag catches stalled slaves. Sits between mips_cpu_bus internals and mips_memory.
// PARAMETERS
//  MAX_WAIT   default 64   cycles a granted transfer may stall before timeout_err is set (1..65535)
//  CNT_W      default 16   width of the stall counter; MAX_WAIT must fit in CNT_W bits
// PORTS
//  clk             in   1   rising-edge clock
//  rst             in   1   synchronous, active-high reset
//  m0_address      in   32  M0 byte address; held stable while m0_waitrequest=1
//  m0_read         in   1   M0 read request
//  m0_write        in   1   M0 write request
//  m0_byteenable   in   4   M0 byte lanes
//  m0_writedata    in   32  M0 write data
//  m0_readdata     out  32  = s_readdata (broadcast)
//  m0_waitrequest  out  1   M0 stall; 0 only in the cycle M0's transfer completes
//  m1_*            same set as m0_*, for M1
//  s_address       out  32  address of granted master, 0 when idle
//  s_read          out  1   read of granted master
//  s_write         out  1   write of granted master
//  s_byteenable    out  4   byte lanes of granted master, 0 when idle
//  s_writedata     out  32  write data of granted master, 0 when idle
//  s_readdata      in   32  slave read data
//  s_waitrequest   in   1   slave stall
//  grant           out  2   one-hot owner: 01=M0, 10=M1, 00=idle
//  timeout_err     out  1   sticky stall-timeout flag
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): state=IDLE, grant=00, stall count=0, timeout_err=0, last-owner=M1.
//    While rst=1 s_read/s_write forced 0 combinationally, both m*_waitrequest=1.
//  - Request: mX_req = mX_read | mX_write. If both read and write asserted, write wins; s_read=0.
//  - FSM states IDLE, GNT0, GNT1 (registered; grant decodes state).
//    IDLE: no request -> IDLE; one request -> that GNTx; both -> per priority rule below.
//    GNTx: req_x=1 & s_waitrequest=0 -> transfer completes this edge -> IDLE.
//          req_x=0 (master dropped request, protocol violation) -> IDLE, no transfer.
//          else stay GNTx.
//  - Latency: request seen at edge N -> slave signals driven from after edge N; minimum 2 cycles
//    per transfer (IDLE cycle + completing cycle). No back-to-back grant without an IDLE cycle.
//  - Slave side muxed combinationally from granted master; in IDLE all s_* outputs are 0.
//  - mX_waitrequest = (state==GNTx) ? s_waitrequest : 1. Non-owner always stalled.
//  - Stall counter: cleared on entry to GNTx; +1 each GNTx cycle with s_waitrequest=1; saturates
//    at all-ones. When counter == MAX_WAIT-1 and s_waitrequest=1, timeout_err set (sticky until rst).
//    Transfer is NOT aborted on timeout.
//  - Priority (default): both requesting in IDLE -> M1 (data) wins; M0 waits.
//  - last-owner register updated on every IDLE->GNTx transition.
//  - Request arriving in the same cycle a transfer completes is served after the IDLE cycle.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, grant the master that is not
//    last-owner (first contest after reset goes to M0). Single requests unaffected.
//  ARB_ROUND_ROBIN_EN undefined: fixed priority M1 > M0; last-owner register kept but unused.
// TESTING
//  1 Reset: rst=1 two edges -> grant=00, s_read=s_write=0, m0/m1_waitrequest=1, timeout_err=0.
//  2 M0 read 0xBFC00000, slave waitrequest=0 -> grant=01 after 1 edge, s_address=0xBFC00000,
//    m0_waitrequest=0 that cycle, m0_readdata=s_readdata, back to grant=00 next edge.
//  3 M0 and M1 request same cycle (M1 write 0x00001000, data 0xDEADBEEF, be=4'b0011) ->
//    default: M1 granted first, s_writedata=0xDEADBEEF, s_byteenable=0011, then M0;
//    with ARB_ROUND_ROBIN_EN: M0 first, then M1, next contest M1 first.
//  4 MAX_WAIT=4, slave holds waitrequest=1 for 10 cycles -> timeout_err=1 after 4th stall cycle,
//    transfer still completes when waitrequest drops; flag stays 1 until rst.
//  5 rst asserted mid-GNT1 with s_waitrequest=1 -> s_write=0 same cycle, grant=00 after edge,
//    timeout_err=0, M1 re-granted only after it re-requests post-reset.
//  6 M1 read+write both 1 -> s_write=1, s_read=0; M0 drops read mid-grant -> IDLE next edge.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
// Two-master / one-slave arbiter for the MIPS CPU memory bus with a sticky stall-timeout flag.
// Optional ARB_ROUND_ROBIN_EN: alternate ownership on simultaneous requests instead of fixed M1 priority.
module mips_bus_arbiter #(
   parameter int unsigned MAX_WAIT = 64,
   parameter int unsigned CNT_W    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [3:0]  m0_byteenable,
   input  logic [31:0] m0_writedata,
   output logic [31:0] m0_readdata,
   output logic        m0_waitrequest,
   input  logic [31:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [3:0]  m1_byteenable,
   input  logic [31:0] m1_writedata,
   output logic [31:0] m1_readdata,
   output logic        m1_waitrequest,
   output logic [31:0] s_address,
   output logic        s_read,
   output logic        s_write,
   output logic [3:0]  s_byteenable,
   output logic [31:0] s_writedata,
   input  logic [31:0] s_readdata,
   input  logic        s_waitrequest,
   output logic [1:0]  grant,
   output logic        timeout_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LP_TIMEOUT_CNT = CNT_W'(MAX_WAIT - 1);

   state_t           r_state;
   state_t           w_next;
   logic             r_last_m1;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             r_timeout;
   logic             w_m0_req;
   logic             w_m1_req;
   logic             w_pick_m1;

   assign w_m0_req = m0_read | m0_write;
   assign w_m1_req = m1_read | m1_write;

`ifdef ARB_ROUND_ROBIN_EN
   assign w_pick_m1 = ~r_last_m1;
`else
   logic w_unused_last;
   assign w_pick_m1     = 1'b1;
   assign w_unused_last = r_last_m1;
`endif

   // Grant state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Ownership is released on completion or when the owner drops its request
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_m0_req && w_m1_req) w_next = w_pick_m1 ? GNT1 : GNT0;
            else if (w_m1_req)        w_next = GNT1;
            else if (w_m0_req)        w_next = GNT0;
         end
         GNT0:    if (!w_m0_req || !s_waitrequest) w_next = IDLE;
         GNT1:    if (!w_m1_req || !s_waitrequest) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Stall counter, sticky timeout and last-owner tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_timeout   <= 1'b0;
         r_last_m1   <= 1'b1;
      end else begin
         if (r_state == IDLE)
            r_stall_cnt <= '0;
         else if (s_waitrequest && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if ((r_state != IDLE) && s_waitrequest && (r_stall_cnt == LP_TIMEOUT_CNT))
            r_timeout <= 1'b1;
         if ((r_state == IDLE) && (w_next != IDLE))
            r_last_m1 <= (w_next == GNT1);
      end
   end

   // Slave-side mux; write wins when a master asserts read and write together
   always_comb begin
      s_address    = '0;
      s_read       = 1'b0;
      s_write      = 1'b0;
      s_byteenable = '0;
      s_writedata  = '0;
      case (r_state)
         GNT0: begin
            s_address    = m0_address;
            s_read       = m0_read & ~m0_write;
            s_write      = m0_write;
            s_byteenable = m0_byteenable;
            s_writedata  = m0_writedata;
         end
         GNT1: begin
            s_address    = m1_address;
            s_read       = m1_read & ~m1_write;
            s_write      = m1_write;
            s_byteenable = m1_byteenable;
            s_writedata  = m1_writedata;
         end
         default: ;
      endcase
      if (rst) begin
         s_read  = 1'b0;
         s_write = 1'b0;
      end
   end

   assign m0_readdata    = s_readdata;
   assign m1_readdata    = s_readdata;
   assign m0_waitrequest = (!rst && (r_state == GNT0)) ? s_waitrequest : 1'b1;
   assign m1_waitrequest = (!rst && (r_state == GNT1)) ? s_waitrequest : 1'b1;
   assign grant          = {r_state == GNT1, r_state == GNT0};
   assign timeout_err    = r_timeout;

endmodule
